ov7670_capture: RTL and testbench
=================================

OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640, meaning the number of pixels per line.
REQ-002 SHALL have parameter V_LINES, default 480, meaning the number of lines per frame.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning the flop depth of the input synchronizer (minimum 2).
REQ-004 SHALL have port clk, input, width 1: the single system clock; every flop is on its rising edge.
REQ-005 SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-006 SHALL have port i_pclk, input, width 1: camera pixel clock, asynchronous to clk.
REQ-007 SHALL have port i_vsync, input, width 1: camera VSYNC, high during vertical blanking.
REQ-008 SHALL have port i_href, input, width 1: camera HREF, high while line bytes are valid.
REQ-009 SHALL have port i_data, input, width 8: camera data bus D[7:0].
REQ-010 SHALL have port o_pixel, output, width 16: assembled RGB565 pixel.
REQ-011 SHALL have port o_valid, output, width 1: one-cycle strobe qualifying o_pixel, o_x and o_y.
REQ-012 SHALL have port o_x, output, width $clog2(H_PIXELS): column of the current pixel.
REQ-013 SHALL have port o_y, output, width $clog2(V_LINES): row of the current pixel.
REQ-014 SHALL have port o_sof, output, width 1: high with o_valid for pixel (0,0) only.
REQ-015 SHALL have port o_frame_done, output, width 1: one-cycle pulse at end of frame.
REQ-016 SHALL have port o_frame_err, output, width 1: valid while o_frame_done is high; set when the frame geometry was wrong.

Function
REQ-017 SHALL pass i_pclk, i_vsync, i_href and i_data through SYNC_STAGES-deep flop chains of equal depth before any use.
REQ-018 SHALL detect a pclk rise as synced pclk=1 with its previous value 0; all sampling SHALL occur only on detect cycles.
REQ-019 SHALL operate correctly for i_pclk frequency no greater than clk/4.
REQ-020 SHALL implement states IDLE, WAIT_VS, ACTIVE; reset enters IDLE.
REQ-021 In IDLE, SHALL go to WAIT_VS when synced vsync is 1.
REQ-022 In WAIT_VS, SHALL go to ACTIVE on a synced vsync 1->0 edge, clearing x, y, byte phase and error state.
REQ-023 In ACTIVE, on a detect cycle with synced href=1, SHALL latch the byte: phase 0 -> o_pixel[15:8], phase 1 -> o_pixel[7:0]; phase then toggles.
REQ-024 SHALL pulse o_valid exactly one clk cycle after the detect cycle that latches a phase-1 byte.
REQ-025 SHALL increment x after each emitted pixel; pixels with x >= H_PIXELS SHALL be dropped (no o_valid) and SHALL set the error state.
REQ-026 On a synced href 1->0 edge, SHALL clear phase to 0 and x to 0 and increment y; a dangling phase-1-pending byte SHALL be discarded and SHALL set the error state.
REQ-027 SHALL set the error state when a line ends with x != H_PIXELS.
REQ-028 SHALL drop lines with y >= V_LINES and set the error state.
REQ-029 On a synced vsync 0->1 edge in ACTIVE, SHALL pulse o_frame_done for one cycle, drive o_frame_err = (error state OR y != V_LINES), and go to WAIT_VS.
REQ-030 A vsync rise mid-line SHALL abort the line, discard pending bytes, and be reported via o_frame_done with o_frame_err=1.
REQ-031 Data sampled while href=0 or outside ACTIVE SHALL be ignored.

Reset
REQ-032 While rst_n=0, SHALL force state=IDLE, synchronizers, x, y and phase to 0, and o_pixel=0, o_valid=0, o_x=0, o_y=0, o_sof=0, o_frame_done=0, o_frame_err=0.
REQ-033 Reset asserted mid-frame SHALL discard the frame with no o_frame_done; after release, capture SHALL resume only after a complete vsync high->low sequence.

Verification
REQ-034 Frame H_PIXELS=4, V_LINES=2, pclk=clk/8, bytes 0x12,0x34,... -> first o_valid gives o_pixel=0x1234, o_x=0, o_y=0, o_sof=1; 8 o_valid pulses total; o_frame_done=1 with o_frame_err=0.
REQ-035 Line of 9 bytes (H_PIXELS=4) -> 4 pixels emitted, odd byte discarded, o_frame_err=1 at frame end.
REQ-036 Line of 12 bytes (H_PIXELS=4) -> only x=0..3 emitted, o_frame_err=1.
REQ-037 vsync rises after 3 pixels of line 0 -> o_frame_done pulse with o_frame_err=1; the next full frame is captured cleanly with o_frame_err=0.
REQ-038 rst_n pulsed low mid-line -> all outputs 0 immediately; no o_valid until after the next vsync falling edge; the next frame starts at o_x=0, o_y=0 with o_sof=1.
REQ-039 Capture begins while vsync is already low -> no output until a full vsync high->low sequence occurs.

Source files
------------

// File: rtl/ov7670_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ov7670_capture                                                             |
// | Captures OV7670 RGB565 byte stream into pixels with x/y and frame checks.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ov7670_capture #(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_pclk,
  input  logic                        i_vsync,
  input  logic                        i_href,
  input  logic [7:0]                  i_data,
  output logic [15:0]                 o_pixel,
  output logic                        o_valid,
  output logic [$clog2(H_PIXELS)-1:0] o_x,
  output logic [$clog2(V_LINES)-1:0]  o_y,
  output logic                        o_sof,
  output logic                        o_frame_done,
  output logic                        o_frame_err
);

  localparam int XW  = $clog2(H_PIXELS);
  localparam int YW  = $clog2(V_LINES);
  // Internal counters carry one extra value so "one past the end" is representable
  localparam int XCW = $clog2(H_PIXELS + 1);
  localparam int YCW = $clog2(V_LINES + 1);

  localparam logic [XCW-1:0] c_H_END = XCW'(H_PIXELS);
  localparam logic [YCW-1:0] c_V_END = YCW'(V_LINES);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_WAIT_VS = 2'd1;
  localparam logic [1:0] c_ACTIVE  = 2'd2;

  logic [1:0]                  r_state;
  logic [SYNC_STAGES-1:0]      r_pclk_sync;
  logic [SYNC_STAGES-1:0]      r_vs_sync;
  logic [SYNC_STAGES-1:0]      r_href_sync;
  logic [SYNC_STAGES-1:0][7:0] r_data_sync;
  logic                        r_pclk_d;
  logic                        r_vs_d;
  logic                        r_href_d;
  logic [XCW-1:0]              r_x;
  logic [YCW-1:0]              r_y;
  logic                        r_phase;
  logic                        r_err;
  logic [15:0]                 r_pixel;
  logic                        r_valid;
  logic [XW-1:0]               r_ox;
  logic [YW-1:0]               r_oy;
  logic                        r_sof;
  logic                        r_done;
  logic                        r_ferr;

  logic       w_pclk;
  logic       w_vs;
  logic       w_href;
  logic [7:0] w_data;
  logic       w_pclk_rise;
  logic       w_vs_rise;
  logic       w_vs_fall;
  logic       w_href_fall;

  assign w_pclk      = r_pclk_sync[SYNC_STAGES-1];
  assign w_vs        = r_vs_sync[SYNC_STAGES-1];
  assign w_href      = r_href_sync[SYNC_STAGES-1];
  assign w_data      = r_data_sync[SYNC_STAGES-1];
  assign w_pclk_rise = w_pclk & ~r_pclk_d;
  assign w_vs_rise   = w_vs & ~r_vs_d;
  assign w_vs_fall   = ~w_vs & r_vs_d;
  assign w_href_fall = ~w_href & r_href_d;

  // Equal-depth chains keep data aligned with the pclk edge that qualifies it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pclk_sync <= '0;
      r_vs_sync   <= '0;
      r_href_sync <= '0;
      r_data_sync <= '0;
      r_pclk_d    <= 1'b0;
      r_vs_d      <= 1'b0;
      r_href_d    <= 1'b0;
    end else begin
      r_pclk_sync <= {r_pclk_sync[SYNC_STAGES-2:0], i_pclk};
      r_vs_sync   <= {r_vs_sync[SYNC_STAGES-2:0], i_vsync};
      r_href_sync <= {r_href_sync[SYNC_STAGES-2:0], i_href};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_data};
      r_pclk_d    <= w_pclk;
      r_vs_d      <= w_vs;
      r_href_d    <= w_href;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_phase <= 1'b0;
      r_err   <= 1'b0;
      r_pixel <= '0;
      r_valid <= 1'b0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_sof   <= 1'b0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_vs) r_state <= c_WAIT_VS;
        end
        c_WAIT_VS: begin
          if (w_vs_fall) begin
            r_state <= c_ACTIVE;
            r_x     <= '0;
            r_y     <= '0;
            r_phase <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        c_ACTIVE: begin
          if (w_vs_rise) begin
            // A short frame or an aborted line leaves y below the line count
            r_done  <= 1'b1;
            r_ferr  <= r_err | (r_y != c_V_END);
            r_phase <= 1'b0;
            r_state <= c_WAIT_VS;
          end else if (w_href_fall) begin
            if (r_phase || (r_x != c_H_END) || (r_y == c_V_END)) r_err <= 1'b1;
            r_phase <= 1'b0;
            r_x     <= '0;
            if (r_y != c_V_END) r_y <= r_y + YCW'(1);
          end else if (w_pclk_rise && w_href) begin
            if (r_y == c_V_END) begin
              r_err <= 1'b1;
            end else if (!r_phase) begin
              r_pixel[15:8] <= w_data;
              r_phase       <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (r_x == c_H_END) begin
                r_err <= 1'b1;
              end else begin
                r_pixel[7:0] <= w_data;
                r_valid      <= 1'b1;
                r_ox         <= r_x[XW-1:0];
                r_oy         <= r_y[YW-1:0];
                r_sof        <= (r_x == '0) && (r_y == '0);
                r_x          <= r_x + XCW'(1);
              end
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign o_pixel      = r_pixel;
  assign o_valid      = r_valid;
  assign o_x          = r_ox;
  assign o_y          = r_oy;
  assign o_sof        = r_sof;
  assign o_frame_done = r_done;
  assign o_frame_err  = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ov7670_capture                                                          |
// | Frame-level bench: camera byte streams against a pixel/geometry model.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ov7670_capture;

  localparam int H = 4;
  localparam int V = 2;

  logic        clk;
  logic        rst_n;
  logic        i_pclk;
  logic        i_vsync;
  logic        i_href;
  logic [7:0]  i_data;
  logic [15:0] o_pixel;
  logic        o_valid;
  logic [1:0]  o_x;
  logic [0:0]  o_y;
  logic        o_sof;
  logic        o_frame_done;
  logic        o_frame_err;

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_pclk(i_pclk), .i_vsync(i_vsync),
    .i_href(i_href), .i_data(i_data), .o_pixel(o_pixel), .o_valid(o_valid),
    .o_x(o_x), .o_y(o_y), .o_sof(o_sof), .o_frame_done(o_frame_done),
    .o_frame_err(o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pix;
    int          x;
    int          y;
    logic        sof;
  } pix_t;

  typedef struct {
    int nlines;
    int len0;
    int len1;
    int len2;
    int abort_line;
    int abort_byte;
    int seq;
    int exp_npix;
    int exp_err;
  } vec_t;

  pix_t exp_q[$];
  pix_t got_q[$];
  int   done_cnt;
  logic last_ferr;
  int   checks;
  int   failures;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) got_q.push_back('{o_pixel, int'(o_x), int'(o_y), o_sof});
      if (o_frame_done) begin
        done_cnt++;
        last_ferr = o_frame_err;
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic pclk_cycle(input logic h, input logic [7:0] d);
    i_pclk = 1'b0;
    i_href = h;
    i_data = d;
    repeat (4) @(posedge clk);
    #1 i_pclk = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Expected pixels follow from the byte stream: bytes pair up in order,
  // only the first H pairs of the first V lines are emitted.
  task automatic run_frame(input vec_t v, output int model_err);
    int         k;
    int         lens[3];
    logic       aborted;
    logic [7:0] hi;
    logic [7:0] b;
    k = 0; aborted = 1'b0; model_err = 0; hi = 8'h00;
    lens[0] = v.len0; lens[1] = v.len1; lens[2] = v.len2;
    exp_q.delete(); got_q.delete(); done_cnt = 0;
    i_vsync = 1'b1; repeat (3) pclk_cycle(1'b0, 8'h00);
    i_vsync = 1'b0; repeat (3) pclk_cycle(1'b0, 8'h00);
    for (int l = 0; l < v.nlines && !aborted; l++) begin
      for (int bi = 0; bi < lens[l]; bi++) begin
        if (l == v.abort_line && bi == v.abort_byte) begin
          aborted = 1'b1;
          break;
        end
        b = (v.seq != 0) ? 8'h12 + 8'(k * 34) : 8'($urandom);
        k++;
        if (bi % 2 == 0) hi = b;
        else if (bi / 2 < H && l < V)
          exp_q.push_back('{{hi, b}, bi / 2, l, (l == 0 && bi == 1)});
        pclk_cycle(1'b1, b);
      end
      if (lens[l] != 2 * H) model_err = 1;
      if (aborted) begin
        i_vsync = 1'b1;
        repeat (6) @(posedge clk);
        #1 i_href = 1'b0;
      end else begin
        repeat (2) pclk_cycle(1'b0, 8'h00);
      end
    end
    if (aborted || v.nlines != V) model_err = 1;
    i_vsync = 1'b1;
    repeat (3) pclk_cycle(1'b0, 8'h00);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input vec_t v, input int idx);
    int merr;
    int n;
    run_frame(v, merr);
    chk($sformatf("npix_tbl[%0d]", idx), got_q.size(), v.exp_npix);
    chk($sformatf("npix_model[%0d]", idx), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("pixel[%0d.%0d]", idx, i),
          {got_q[i].pix, 8'(got_q[i].x), 8'(got_q[i].y), got_q[i].sof},
          {exp_q[i].pix, 8'(exp_q[i].x), 8'(exp_q[i].y), exp_q[i].sof});
    chk($sformatf("frame_done_cnt[%0d]", idx), done_cnt, 1);
    chk($sformatf("frame_err_tbl[%0d]", idx), last_ferr, v.exp_err);
    chk($sformatf("frame_err_model[%0d]", idx), last_ferr, merr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vec_t clean;
    checks = 0; failures = 0; done_cnt = 0; last_ferr = 1'b0;
    //          nl len0 len1 len2 abl abb seq npix err
    vecs[0] = '{2,  8,   8,   0,  -1, 0,  1,  8,   0};
    vecs[1] = '{2,  9,   8,   0,  -1, 0,  0,  8,   1};
    vecs[2] = '{2,  12,  8,   0,  -1, 0,  0,  8,   1};
    vecs[3] = '{1,  8,   0,   0,  -1, 0,  0,  4,   1};
    vecs[4] = '{3,  8,   8,   8,  -1, 0,  0,  8,   1};
    vecs[5] = '{2,  8,   8,   0,  0,  6,  0,  3,   1};
    vecs[6] = '{2,  8,   8,   0,  -1, 0,  0,  8,   0};
    vecs[7] = '{2,  6,   8,   0,  -1, 0,  0,  7,   1};
    vecs[8] = '{2,  8,   10,  0,  -1, 0,  0,  8,   1};
    clean   = '{2,  8,   8,   0,  -1, 0,  1,  8,   0};

    rst_n = 1'b0; i_pclk = 1'b0; i_vsync = 1'b0; i_href = 1'b0; i_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {o_pixel, o_valid, o_x, o_y, o_sof, o_frame_done, o_frame_err}, 0);
    rst_n = 1'b1;

    // Capture starts with vsync already low: a whole frame must be ignored
    repeat (2) begin
      for (int bi = 0; bi < 2 * H; bi++) pclk_cycle(1'b1, 8'($urandom));
      repeat (2) pclk_cycle(1'b0, 8'h00);
    end
    chk("no_vsync_pixels", got_q.size(), 0);
    chk("no_vsync_done", done_cnt, 0);

    for (int i = 0; i < 9; i++) begin
      check_frame(vecs[i], i);
      if (i == 0 && got_q.size() > 0)
        chk("first_pixel", {got_q[0].pix, 8'(got_q[0].x), 8'(got_q[0].y), got_q[0].sof},
            {16'h1234, 8'd0, 8'd0, 1'b1});
    end

    // Reset pulse in the middle of line 0
    got_q.delete(); done_cnt = 0;
    i_vsync = 1'b1; repeat (3) pclk_cycle(1'b0, 8'h00);
    i_vsync = 1'b0; repeat (3) pclk_cycle(1'b0, 8'h00);
    pclk_cycle(1'b1, 8'h12); pclk_cycle(1'b1, 8'h34); pclk_cycle(1'b1, 8'h56);
    repeat (3) @(posedge clk);
    chk("pre_reset_pixels", got_q.size(), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midline_reset_outputs",
        {o_pixel, o_valid, o_x, o_y, o_sof, o_frame_done, o_frame_err}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    got_q.delete(); done_cnt = 0;
    for (int bi = 0; bi < 5; bi++) pclk_cycle(1'b1, 8'($urandom));
    repeat (2) pclk_cycle(1'b0, 8'h00);
    for (int bi = 0; bi < 2 * H; bi++) pclk_cycle(1'b1, 8'($urandom));
    repeat (2) pclk_cycle(1'b0, 8'h00);
    i_vsync = 1'b1;
    repeat (3) pclk_cycle(1'b0, 8'h00);
    chk("post_reset_pixels", got_q.size(), 0);
    chk("post_reset_done", done_cnt, 0);
    check_frame(clean, 100);
    if (got_q.size() > 0)
      chk("post_reset_first", {8'(got_q[0].x), 8'(got_q[0].y), got_q[0].sof},
          {8'd0, 8'd0, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
